// File: rtl/uart_apb_master.sv
// Command-driven APB requester: parses opcode/address/data frames from a UART byte stream,
// performs one APB transfer, and returns a status byte (plus read data) over a UART Tx handshake.
module uart_apb_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Done,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  o_busy
);

  localparam int unsigned AddrBytes = ADDR_WIDTH / 8;
  localparam int unsigned DataBytes = DATA_WIDTH / 8;
  localparam int unsigned CntW      = 3;
  localparam int unsigned WaitW     = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OpWrite   = 8'h57;
  localparam logic [7:0] OpRead    = 8'h52;
  localparam logic [7:0] StatOk    = 8'h4B;
  localparam logic [7:0] StatErr   = 8'h45;
  localparam logic [7:0] StatTmo   = 8'h54;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StSetup, StAccess, StResp} state_e;

  state_e                state_q;
  logic                  write_q;
  logic [CntW-1:0]       byte_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [WaitW-1:0]      wait_q;
  logic [CntW-1:0]       resp_left_q;
  logic                  tx_pend_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  tx_dv_q;
  logic [7:0]            tx_byte_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
      resp_left_q <= '0;
      tx_pend_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_Rx_DV && (i_Rx_Byte == OpWrite || i_Rx_Byte == OpRead)) begin
            write_q    <= (i_Rx_Byte == OpWrite);
            byte_cnt_q <= '0;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          if (i_Rx_DV) begin
            addr_q <= (addr_q << 8) | ADDR_WIDTH'(i_Rx_Byte);
            if (byte_cnt_q == CntW'(AddrBytes - 1)) begin
              byte_cnt_q <= '0;
              if (write_q) begin
                state_q <= StData;
              end else begin
                state_q <= StSetup;
                psel_q  <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (i_Rx_DV) begin
            wdata_q <= (wdata_q << 8) | DATA_WIDTH'(i_Rx_Byte);
            if (byte_cnt_q == CntW'(DataBytes - 1)) begin
              byte_cnt_q <= '0;
              state_q    <= StSetup;
              psel_q     <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + CntW'(1);
            end
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // pready is checked first so it wins over a coincident timeout
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            tx_pend_q   <= 1'b0;
            tx_byte_q   <= pslverr ? StatErr : StatOk;
            resp_left_q <= (!write_q && !pslverr) ? CntW'(DataBytes) : '0;
            if (!write_q) rdata_q <= prdata;
            state_q     <= StResp;
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            tx_pend_q   <= 1'b0;
            tx_byte_q   <= StatTmo;
            resp_left_q <= '0;
            state_q     <= StResp;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StResp: begin
          if (!tx_pend_q) begin
            tx_dv_q   <= 1'b1;
            tx_pend_q <= 1'b1;
          end else if (i_Tx_Done) begin
            tx_pend_q <= 1'b0;
            if (resp_left_q == '0) begin
              state_q <= StIdle;
            end else begin
              tx_byte_q   <= rdata_q[DATA_WIDTH-1 -: 8];
              rdata_q     <= rdata_q << 8;
              resp_left_q <= resp_left_q - CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pwrite    = write_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_busy    = (state_q != StIdle);

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
- Command-driven APB requester that drives the APB slave interface (`sel`, `write`) of the peripheral complex.
- Consumes byte strobes from a UART receiver.
- Issues one APB read or write per command frame, then returns a status byte, plus read data for reads, through a UART transmitter byte handshake.
- Sits between the UART byte layer and the APB fabric.

Parameters:
- ADDR_WIDTH, 16, APB address width; multiple of 8, 8..32.
- DATA_WIDTH, 32, APB data width; multiple of 8, 8..32.
- TIMEOUT, 255, max ACCESS cycles waiting for `pready` before abort; must be ≥1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_Rx_DV`  in  1  one-cycle strobe: `i_Rx_Byte` is valid.
- `i_Rx_Byte`  in  8  received byte.
- `o_Tx_DV`  out  1  one-cycle strobe: start transmitting `o_Tx_Byte`.
- `o_Tx_Byte`  out  8  byte to transmit; held stable until `i_Tx_Done`.
- `i_Tx_Done`  in  1  one-cycle strobe from transmitter: byte finished.
- `paddr`  out  ADDR_WIDTH  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction, 1 = write.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `o_busy`  out  1  high in every state except IDLE.

Behaviour:
- **Reset (`reset` = 0, async):** state = IDLE.
  - `psel`, `penable`, `pwrite`, `o_Tx_DV`, `o_busy` = 0.
  - `paddr`, `pwdata`, `o_Tx_Byte`, internal registers = 0.
- **Frame format:** opcode, then ADDR_WIDTH/8 address bytes MSB first, then (write only) DATA_WIDTH/8 data bytes MSB first.
  - Opcode 0x57 = write, 0x52 = read.
- **IDLE:**
  - On `i_Rx_DV` with 0x57 or 0x52: latch the direction, clear the byte counter, go to ADDR.
  - Any other opcode is discarded; stay in IDLE with no response.
- **ADDR:** each `i_Rx_DV` shifts the byte into the address register from the LSB end. After the last address byte, go to DATA (write) or SETUP (read).
- **DATA:** same shifting into the write-data register. After the last data byte, go to SETUP.
- **SETUP, exactly 1 cycle:**
  - `psel` = 1, `penable` = 0.
  - `paddr`, `pwrite`, `pwdata` driven from the registers and held stable through ACCESS.
  - Next state: ACCESS.
- **ACCESS:** `psel` = 1, `penable` = 1, wait counter increments each cycle.
  - **`pready` = 1:** capture `prdata` (read) and `pslverr`; deassert `psel`/`penable` next cycle.
    - Status = 0x45 (`E`) if `pslverr`, else 0x4B (`K`).
    - Go to RESP.
  - **Counter reaches TIMEOUT with `pready` still 0:** deassert `psel`/`penable`, status = 0x54 (`T`), go to RESP.
  - If `pready` rises on the same cycle as the timeout, `pready` wins.
- **RESP:** queues the response.
  - Status byte first.
  - For reads with status `K`: then DATA_WIDTH/8 bytes of captured `prdata`, MSB first.
  - Reads with `E` or `T` send the status byte only. Writes always send the status byte only.
- **Tx handshake:**
  - Pulse `o_Tx_DV` for 1 cycle with `o_Tx_Byte` valid.
  - Wait for `i_Tx_Done` before pulsing the next byte.
  - `o_Tx_DV` is never asserted while a byte is outstanding.
  - After the final `i_Tx_Done`, return to IDLE in the following cycle.
- **Rx bytes outside IDLE/ADDR/DATA:** `i_Rx_DV` in SETUP, ACCESS or RESP is dropped; there is no buffering.
- **Minimum latency:** last frame byte → `psel` rises next cycle. With `pready` tied 1, `o_Tx_DV` first pulses 3 cycles after `psel` rises.
- **Counters:** sized for TIMEOUT and for the max byte count; no wrap within a frame.
- **Async reset mid-transfer:** APB and Tx strobes drop immediately and the partial frame is lost.

Test Plan:
1. Rx 57 12 34 DE AD BE EF, `pready` = 1, `pslverr` = 0 → one APB write:
   - `paddr` = 0x1234, `pwdata` = 0xDEADBEEF, SETUP then ACCESS 1 cycle each.
   - Tx bytes: 4B.
2. Rx 52 00 08, slave inserts 3 wait states, `prdata` = 0xCAFEF00D → `penable` high for 4 cycles.
   - Tx: 4B CA FE F0 0D; each `o_Tx_DV` only after the prior `i_Tx_Done`.
3. Rx 52 00 10, `pslverr` = 1 with `pready` → Tx: 45 only; `psel` = 0 after the response.
4. Rx 57 00 04 00 00 00 01, `pready` stuck 0 → ACCESS lasts exactly 255 cycles, then abort; Tx: 54; state returns to IDLE.
5. Rx 41 then 52 00 20 → 0x41 ignored with no Tx; the read executes normally at `paddr` = 0x0020.
6. `reset` asserted in ACCESS and in RESP (between `o_Tx_DV` and `i_Tx_Done`) → all outputs 0 immediately.
   - A subsequent write frame completes correctly.
